// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer and its PISO counterpart.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

endpackage : sipo_pkg

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for assembled words, with sticky overrun.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun
);

    logic accept_c;
    logic drop_c;

    // A slot frees up in the same cycle it is consumed, so back-to-back words never drop.
    assign accept_c = load && (!out_valid || out_ready);
    assign drop_c   = load && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (accept_c) begin
            data_out  <= word;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Set wins over a simultaneous clear so a fresh loss is never masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule : sipo_out_buf

// File: rtl/sipo_deserializer.sv
// Rebuilds WIDTH-bit words from a start-framed serial stream; hands them to a one-entry output buffer.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    sipo_state_t      state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] shifted_c;
    logic [WIDTH-1:0] fresh_c;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_c;

    // Shift direction fixes which end of the word the first serial bit ends up in.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_c = {shreg[WIDTH-2:0], in};
            fresh_c   = {{(WIDTH-1){1'b0}}, in};
        end else begin
            shifted_c = {in, shreg[WIDTH-1:1]};
            fresh_c   = {in, {(WIDTH-1){1'b0}}};
        end
    end

    // start always restarts framing, even on what would have been the completing edge.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done_c    = 1'b0;
        if (start) begin
            state_nxt = SHIFT;
            shreg_nxt = in_valid ? fresh_c : '0;
            cnt_nxt   = in_valid ? CNT_W'(1) : '0;
        end else if (state == SHIFT && in_valid) begin
            shreg_nxt = shifted_c;
            if (cnt == CNT_W'(WIDTH - 1)) begin
                done_c    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == SHIFT);
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst),
        .load      (done_c),
        .word      (shifted_c),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule : sipo_deserializer

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Downstream consumer of the PISO serializer: rebuilds WIDTH-bit parallel words from the single-bit serial stream.
- A start strobe frames each word; a one-entry output buffer with valid/ready handshake lets a new frame shift in while the previous word awaits pickup.
- Sticky overrun flag reports words lost when the consumer stalls.

Parameters:
- WIDTH, 8, bits per frame (>= 2).
- MSB_FIRST, 1, 1 = first serial bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in  input  1  serial data bit (PISO out).
- in_valid  input  1  qualifies in; a bit is taken only on edges with in_valid=1.
- start  input  1  frame start; coincides with the first bit of a frame.
- data_out  output  WIDTH  assembled word, stable while out_valid=1.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts; transfer on edge with out_valid && out_ready.
- busy  output  1  frame in progress (state SHIFT).
- overrun  output  1  sticky; a completed frame was dropped.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous): data_out=0, out_valid=0, busy=0, overrun=0, shift register=0, bit count=0, state IDLE.
- States: IDLE, SHIFT. busy=1 iff state==SHIFT.
- IDLE: start=1 -> SHIFT. If in_valid=1 on that edge, the bit is shifted in and count=1; else count=0.
- IDLE: start=0 -> ignore in/in_valid.
- SHIFT: each edge with in_valid=1 shifts in one bit and increments count. in_valid=0 holds all state (gaps allowed, no timeout).
- MSB_FIRST=1: shift left, new bit into LSB. MSB_FIRST=0: shift right, new bit into MSB.
- Frame completion: the edge taking bit number WIDTH. On that edge the assembled word goes to the output stage, count clears, and state -> IDLE.
- Latency: data_out/out_valid are visible the cycle after the last bit is sampled.
- start=1 while in SHIFT: partial word silently discarded; count restarts exactly as for IDLE+start. No error flag.
- Start on the completing edge of a frame (count==WIDTH-1, in_valid=1): treated as a restart. The partial word is discarded and no word is output.
- Output stage, on the completion edge:
  - out_valid=0, or out_valid && out_ready: load data_out, out_valid=1 (back-to-back frames lose nothing).
  - out_valid=1 && out_ready=0: new word dropped, data_out unchanged, overrun<=1.
- Output stage, no completion: out_valid && out_ready -> out_valid<=0; data_out keeps its last value.
- overrun: set as above. clr_ovr=1 clears it. Set has priority over a simultaneous clr_ovr.
- Reset mid-frame: all state cleared immediately; the next frame needs a fresh start.
- Count register width: $clog2(WIDTH+1). Count never exceeds WIDTH-1 at rest.

Decomposition:
- Shared package sipo_pkg:
  - state enum {IDLE, SHIFT}.
  - default WIDTH constant, shared with the PISO bench.
- Natural sub-module sipo_out_buf: the one-entry valid/ready holding register plus overrun logic.
- Top holds the FSM, the shift register and the counter.

Test Plan:
- WIDTH=8, MSB_FIRST=1: start with the first bit, then 8 consecutive bits 1,1,1,1,0,0,0,0, out_ready=1 -> data_out=8'hF0, out_valid high for exactly 1 cycle, the cycle after bit 8.
- Same frame with in_valid=0 for 3 cycles after bits 2 and 5 -> data_out=8'hF0; busy stays 1 through the gaps.
- MSB_FIRST=0, bits 1,0,1,0,0,0,0,0 -> data_out=8'h05.
- out_ready=0. Frame A=8'hF0 completes, then frame B=8'h0F completes -> data_out stays 8'hF0, overrun=1. Then out_ready=1 -> out_valid drops. Then clr_ovr=1 -> overrun=0.
- Back-to-back frames 8'hAA then 8'h55 with out_ready=1 -> both delivered in order, overrun=0.
- start after 4 bits of 8'hFF, then full frame 8'h3C -> only 8'h3C output.
- rst=0 after 5 bits -> all outputs 0 asynchronously. The following full frame 8'hC3 decodes correctly.
